shift_counter: RTL and testbench
================================

Name: shift_counter

Overview:
Parametrised ring/Johnson shift counter, WIDTH bits, with ring or Johnson mode selected at run time. Adds count enable, bidirectional shift, parallel load, decoded position index and a wrap pulse. Used as a one-hot/Johnson sequencer for phase generation and time-slot selection in downstream control logic.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32.
IDXW, $clog2(2*WIDTH), width of the idx output. Derived; not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
en  input  1  step enable; one shift per clk edge while high
mode  input  1  0 = ring, 1 = Johnson
dir  input  1  0 = shift toward MSB (left), 1 = toward LSB (right)
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value loaded into q
q  output  WIDTH  counter state (registered)
idx  output  IDXW  position index decoded from q (combinational from registers)
wrap  output  1  one-cycle pulse after a step lands on idx 0 (registered)
illegal  output  1  q is not a legal state for mode_q (see Optional Feature)

Behaviour:
- Reset (rst=0, async): q=1 (LSB only set), mode_q=0, wrap=0. idx is then 0 in ring mode.
- mode_q: internal register holding the last accepted mode. Reset value 0.
- Next-state priority at each clk edge, highest first:
  1. load=1: q<=load_val; mode_q<=mode; wrap<=0.
  2. mode!=mode_q: q<=1; mode_q<=mode; wrap<=0. Applies regardless of en.
  3. Self-correct, option build only: see Optional Feature.
  4. en=1: q<=step(q); wrap<=(idx(step(q))==0).
  5. Otherwise hold q; wrap<=0.
- Step functions (W=WIDTH):
  - Ring left: {q[W-2:0],q[W-1]}.
  - Ring right: {q[0],q[W-1:1]}.
  - Johnson left: {q[W-2:0],~q[W-1]}.
  - Johnson right: {~q[0],q[W-1:1]}.
- Periods: ring = W states; Johnson = 2W states. A direction change mid-sequence reverses through the same states, with no skipped state.
- idx, ring mode: bit position of the single 1.
- idx, Johnson mode: k = popcount(q). If q[0]=1, idx=k. If q[0]=0, idx=0 when k=0, else 2W-k.
  - Example W=4: 0000→0, 0001→1, 0011→2, 0111→3, 1111→4, 1110→5, 1100→6, 1000→7.
- idx is 0 for any illegal state.
- Legality:
  - Ring: exactly one bit set.
  - Johnson: at most one transition between adjacent bits q[i],q[i+1] over i=0..W-2.
- Boundaries:
  - Left wrap: ring 1000→0001; Johnson 1000→0000.
  - Ring at W=2 alternates 01/10.
  - load and en together: load wins and no step occurs.
  - Reset asserted mid-sequence: q returns to 1 immediately, without waiting for a clock edge.

Optional Feature:
Macro SHIFT_CNT_SELFCORRECT_EN.
- Defined:
  - illegal = combinational legality check of q against mode_q.
  - When illegal=1 and neither priority 1 nor priority 2 applies, the next edge forces q<=1 and wrap<=0, regardless of en.
  - Recovery therefore takes one cycle, including after a load of an illegal value.
- Not defined:
  - illegal is tied 0.
  - Illegal states propagate under the normal step rules. Ring 0000 stays 0000; Johnson 0101 circulates a non-Johnson pattern.

Decomposition:
- Package shift_cnt_pkg holds:
  - Constants MODE_RING=1'b0, MODE_JOHNSON=1'b1, DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - Function idx_width(w) returning $clog2(2*w).
- One sub-module, shift_cnt_decode (purely combinational): inputs q and mode_q; outputs idx and legal. It is instantiated once for q, and once for step(q) to generate wrap.

Test Plan:
- Ring, W=4, rst released, en=1, dir=0, mode=0: q = 0001,0010,0100,1000,0001; wrap high only in the cycle after 1000→0001; idx = 0,1,2,3,0.
- Johnson, W=4, en=1, dir=0: first edge mode change gives q=0001; then 0011,0111,1111,1110,1100,1000,0000; wrap pulses once after 0000; idx follows 1..7,0.
- Direction reversal: Johnson at 0111, set dir=1 → 0011,0001,0000,1000; en=0 for 3 cycles → q holds 1000, wrap=0.
- Load priority: load=1 with load_val=0100, en=1, mode=0 in the same cycle → q=0100, idx=2, no step; mode toggled to 1 next cycle → q=0001.
- Async reset: assert rst=0 between clock edges while q=1000 → q=0001 within the same cycle, wrap=0.
- Option build: load 0101 in ring mode → illegal=1, idx=0, next edge q=0001 with en=0. Non-option build: load 0000 in ring mode, en=1 → q stays 0000 for 8 cycles, illegal=0.

Source files
------------

// File: rtl/shift_cnt_pkg.sv
// Shared constants and helpers for the ring/Johnson shift counter.
// Optional self-correction is enabled by defining SHIFT_CNT_SELFCORRECT_EN.
package shift_cnt_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    function automatic int idx_width(input int w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/shift_cnt_decode.sv
// Combinational position decoder: maps a ring or Johnson state to its index
// and flags whether the state belongs to the selected sequence.
module shift_cnt_decode
    import shift_cnt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDXW  = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    input  logic             mode_q,
    output logic [IDXW-1:0]  idx,
    output logic             legal
);

    localparam int CW = IDXW + 1;

    logic [CW-1:0]   ones;
    logic [CW-1:0]   trans;
    logic [IDXW-1:0] pos;

    always_comb begin
        ones  = '0;
        trans = '0;
        pos   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q[i]) begin
                ones = ones + CW'(1);
                pos  = IDXW'(i);
            end
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (q[i] != q[i+1]) begin
                trans = trans + CW'(1);
            end
        end

        legal = 1'b0;
        idx   = '0;
        if (mode_q == MODE_RING) begin
            legal = (ones == CW'(1));
            if (legal) begin
                idx = pos;
            end
        end else begin
            // A Johnson state is a single run of ones touching one end.
            legal = (trans <= CW'(1));
            if (legal) begin
                if (q[0]) begin
                    idx = IDXW'(ones);
                end else if (ones != '0) begin
                    idx = IDXW'(CW'(2 * WIDTH) - ones);
                end
            end
        end
    end

endmodule

// File: rtl/shift_counter.sv
// Ring/Johnson shift counter with enable, direction, parallel load, index and wrap.
// Define SHIFT_CNT_SELFCORRECT_EN to flag illegal states and force recovery to 1.
module shift_counter
    import shift_cnt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDXW  = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [IDXW-1:0]  idx,
    output logic             wrap,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] Q_INIT = WIDTH'(1);

    logic             mode_q;
    logic [WIDTH-1:0] step_q;
    logic [IDXW-1:0]  step_idx;
    logic             cur_legal;
    logic             unused_step_legal;

    always_comb begin
        step_q = q;
        case ({mode_q, dir})
            {MODE_RING,    DIR_LEFT}:  step_q = {q[WIDTH-2:0], q[WIDTH-1]};
            {MODE_RING,    DIR_RIGHT}: step_q = {q[0], q[WIDTH-1:1]};
            {MODE_JOHNSON, DIR_LEFT}:  step_q = {q[WIDTH-2:0], ~q[WIDTH-1]};
            default:                   step_q = {~q[0], q[WIDTH-1:1]};
        endcase
    end

    shift_cnt_decode #(.WIDTH(WIDTH), .IDXW(IDXW)) u_dec_cur (
        .q      (q),
        .mode_q (mode_q),
        .idx    (idx),
        .legal  (cur_legal)
    );

    // Second decoder looks one step ahead so wrap can be registered.
    shift_cnt_decode #(.WIDTH(WIDTH), .IDXW(IDXW)) u_dec_step (
        .q      (step_q),
        .mode_q (mode_q),
        .idx    (step_idx),
        .legal  (unused_step_legal)
    );

`ifdef SHIFT_CNT_SELFCORRECT_EN
    assign illegal = ~cur_legal;
`else
    logic unused_cur_legal;
    assign unused_cur_legal = cur_legal;
    assign illegal          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= Q_INIT;
            mode_q <= MODE_RING;
            wrap   <= 1'b0;
        end else if (load) begin
            q      <= load_val;
            mode_q <= mode;
            wrap   <= 1'b0;
        end else if (mode != mode_q) begin
            q      <= Q_INIT;
            mode_q <= mode;
            wrap   <= 1'b0;
`ifdef SHIFT_CNT_SELFCORRECT_EN
        end else if (illegal) begin
            q    <= Q_INIT;
            wrap <= 1'b0;
`endif
        end else if (en) begin
            q    <= step_q;
            wrap <= (step_idx == '0);
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_counter.sv
// Bench for shift_counter (WIDTH=4): directed vector table, hand corner cases,
// and randomized stimulus against an index-based reference model.
module tb_shift_counter;

    localparam int W    = 4;
    localparam int IDXW = $clog2(2 * W);

    logic            clk;
    logic            rst;
    logic            en;
    logic            mode;
    logic            dir;
    logic            load;
    logic [W-1:0]    load_val;
    logic [W-1:0]    q;
    logic [IDXW-1:0] idx;
    logic            wrap;
    logic            illegal;

    int checks;
    int errors;

    shift_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .idx      (idx),
        .wrap     (wrap),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         load;
        logic [W-1:0] lv;
        logic         en;
        logic         mode;
        logic         dir;
        logic [W-1:0] eq;
        int           eidx;
        logic         ew;
    } vec_t;

    vec_t tbl[$];

    // Reference model: sequence position -> state value, computed arithmetically.
    function automatic logic [W-1:0] q_of(input logic m, input int i);
        if (!m) return W'(1 << i);
        if (i <= W) return W'((1 << i) - 1);
        return W'(~((1 << (i - W)) - 1));
    endfunction

    function automatic int period(input logic m);
        return m ? 2 * W : W;
    endfunction

    function automatic int idx_of(input logic m, input logic [W-1:0] v);
        for (int j = 0; j < period(m); j++) begin
            if (q_of(m, j) == v) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic ld, input logic [W-1:0] lv, input logic e, input logic m,
                       input logic d, input logic [W-1:0] eq, input int ei, input logic ew);
        vec_t v;
        v.load = ld; v.lv = lv; v.en = e; v.mode = m; v.dir = d;
        v.eq = eq; v.eidx = ei; v.ew = ew;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] m_q;
    logic         m_mode;
    logic         m_wrap;

    task automatic model_edge();
        int p;
        int i;
        int ni;
        if (load) begin
            m_q = load_val; m_mode = mode; m_wrap = 1'b0;
        end else if (mode != m_mode) begin
            m_q = W'(1); m_mode = mode; m_wrap = 1'b0;
        end else if (en) begin
            p  = period(m_mode);
            i  = idx_of(m_mode, m_q);
            ni = dir ? (i + p - 1) % p : (i + 1) % p;
            m_q    = q_of(m_mode, ni);
            m_wrap = (ni == 0);
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;

        // Ring left, wrap, then Johnson full cycle.
        add(0, 4'h0, 1, 0, 0, 4'b0010, 1, 0);
        add(0, 4'h0, 1, 0, 0, 4'b0100, 2, 0);
        add(0, 4'h0, 1, 0, 0, 4'b1000, 3, 0);
        add(0, 4'h0, 1, 0, 0, 4'b0001, 0, 1);
        add(0, 4'h0, 1, 0, 0, 4'b0010, 1, 0);
        add(0, 4'h0, 1, 1, 0, 4'b0001, 1, 0);
        add(0, 4'h0, 1, 1, 0, 4'b0011, 2, 0);
        add(0, 4'h0, 1, 1, 0, 4'b0111, 3, 0);
        add(0, 4'h0, 1, 1, 0, 4'b1111, 4, 0);
        add(0, 4'h0, 1, 1, 0, 4'b1110, 5, 0);
        add(0, 4'h0, 1, 1, 0, 4'b1100, 6, 0);
        add(0, 4'h0, 1, 1, 0, 4'b1000, 7, 0);
        add(0, 4'h0, 1, 1, 0, 4'b0000, 0, 1);
        add(0, 4'h0, 1, 1, 0, 4'b0001, 1, 0);
        add(0, 4'h0, 1, 1, 0, 4'b0011, 2, 0);
        add(0, 4'h0, 1, 1, 0, 4'b0111, 3, 0);
        // Reverse direction through the same states, then hold.
        add(0, 4'h0, 1, 1, 1, 4'b0011, 2, 0);
        add(0, 4'h0, 1, 1, 1, 4'b0001, 1, 0);
        add(0, 4'h0, 1, 1, 1, 4'b0000, 0, 1);
        add(0, 4'h0, 1, 1, 1, 4'b1000, 7, 0);
        add(0, 4'h0, 0, 1, 1, 4'b1000, 7, 0);
        add(0, 4'h0, 0, 1, 1, 4'b1000, 7, 0);
        add(0, 4'h0, 0, 1, 1, 4'b1000, 7, 0);
        // Load beats enable; mode toggle restarts at 1.
        add(1, 4'b0100, 1, 0, 0, 4'b0100, 2, 0);
        add(0, 4'h0, 1, 1, 0, 4'b0001, 1, 0);
        // Ring right, including right wrap.
        add(0, 4'h0, 1, 0, 1, 4'b0001, 0, 0);
        add(0, 4'h0, 1, 0, 1, 4'b1000, 3, 0);
        add(0, 4'h0, 1, 0, 1, 4'b0100, 2, 0);
        add(0, 4'h0, 1, 0, 0, 4'b1000, 3, 0);
        add(0, 4'h0, 1, 0, 0, 4'b0001, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", 32'(q), 32'b0001);
        chk("reset_idx", 32'(idx), 0);
        chk("reset_wrap", 32'(wrap), 0);
        chk("reset_illegal", 32'(illegal), 0);
        rst = 1'b1;

        foreach (tbl[n]) begin
            load = tbl[n].load; load_val = tbl[n].lv; en = tbl[n].en;
            mode = tbl[n].mode; dir = tbl[n].dir;
            tick();
            chk($sformatf("vec%0d_q", n), 32'(q), 32'(tbl[n].eq));
            chk($sformatf("vec%0d_idx", n), 32'(idx), 32'(tbl[n].eidx));
            chk($sformatf("vec%0d_wrap", n), 32'(wrap), 32'(tbl[n].ew));
            chk($sformatf("vec%0d_illegal", n), 32'(illegal), 0);
        end
        load = 1'b0;

        // Async reset between edges while at 1000.
        en = 1'b1; mode = 1'b0; dir = 1'b0;
        repeat (3) tick();
        chk("pre_reset_q", 32'(q), 32'b1000);
        en = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_q", 32'(q), 32'b0001);
        chk("async_reset_wrap", 32'(wrap), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

`ifdef SHIFT_CNT_SELFCORRECT_EN
        load = 1'b1; load_val = 4'b0101; mode = 1'b0; en = 1'b0;
        tick();
        load = 1'b0;
        chk("sc_loaded_q", 32'(q), 32'b0101);
        chk("sc_illegal", 32'(illegal), 1);
        chk("sc_idx", 32'(idx), 0);
        tick();
        chk("sc_recover_q", 32'(q), 32'b0001);
        chk("sc_recover_illegal", 32'(illegal), 0);
`else
        load = 1'b1; load_val = 4'b0000; mode = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("stuck%0d_q", k), 32'(q), 32'b0000);
            chk($sformatf("stuck%0d_illegal", k), 32'(illegal), 0);
            chk($sformatf("stuck%0d_idx", k), 32'(idx), 0);
            tick();
        end
`endif

        // Randomized run against the reference model from a fresh reset.
        en = 1'b0; load = 1'b0; mode = 1'b0; dir = 1'b0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        m_q = W'(1); m_mode = 1'b0; m_wrap = 1'b0;
        for (int k = 0; k < 400; k++) begin
            en  = ($urandom_range(0, 3) != 0);
            dir = ($urandom_range(0, 7) == 0) ? ~dir : dir;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            load = ($urandom_range(0, 9) == 0);
            load_val = q_of(mode, $urandom_range(0, period(mode) - 1));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("rnd%0d_q", k), 32'(q), 32'(m_q));
            chk($sformatf("rnd%0d_idx", k), 32'(idx), 32'(idx_of(m_mode, m_q)));
            chk($sformatf("rnd%0d_wrap", k), 32'(wrap), 32'(m_wrap));
            chk($sformatf("rnd%0d_illegal", k), 32'(illegal), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
